axi_rd_arb2: RTL and testbench
==============================

# axi_rd_arb2

Two-master to one-slave AXI4 read-channel arbiter placed in front of the instruction ROM in HISOC. It lets the RVSEED fetch unit (master 0) share the ROM read port with a second read master (master 1, data/debug loads). One transaction is granted at a time, round-robin. The grant is held from AR handshake through the R beat carrying `rlast`.

## Interface
Parameters (defaults taken from the shared AXI width macros):
- `ID_W`, `AXI_ID_WIDTH`: AR/R ID width.
- `ADDR_W`, `AXI_ADDR_WIDTH`: address width.
- `DATA_W`, `AXI_DATA_WIDTH`: read data width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_arvalid` in 1 / `m0_arready` out 1: master 0 AR handshake.
- `m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot, m0_arqos, m0_arregion`  in  AXI_* widths  master 0 AR payload.
- `m0_rvalid` out 1 / `m0_rready` in 1: master 0 R handshake.
- `m0_rid, m0_rdata, m0_rresp, m0_rlast`  out  ID_W/DATA_W/2/1  master 0 R payload.
- `m1_*`: the same set as `m0_*`, for master 1.
- `s_arvalid` out 1 / `s_arready` in 1: AR handshake to the ROM.
- `s_ar*` payload  out  AXI_* widths  AR payload to the ROM.
- `s_rvalid` in 1 / `s_rready` out 1: R handshake from the ROM.
- `s_rid, s_rdata, s_rresp, s_rlast`  in  R payload from the ROM.
- `arb_grant`  out 1: granted master index; valid while `arb_busy`.
- `arb_busy`  out 1: high in the AR and R states.

## Operation
- FSM states: IDLE, ADDR, DATA. Encoding is 2 bits.
- Round-robin pointer `rr_ptr` (1 bit) names the master with priority this cycle.
- **IDLE**
  - If no master has `arvalid` high, stay in IDLE.
  - If only one master has `arvalid` high, register `arb_grant` = that master and go to ADDR.
  - If both are high, the master named by `rr_ptr` wins; go to ADDR.
- **ADDR**
  - `s_arvalid` = `arvalid` of the granted master; `s_ar*` = its AR payload (combinational mux).
  - `arready` of the granted master = `s_arready`. `arready` of the other master = 0.
  - On `s_arvalid & s_arready`, go to DATA.
- **DATA**
  - `rvalid` of the granted master = `s_rvalid`; its R payload = `s_r*`.
  - `s_rready` = `rready` of the granted master.
  - The other master sees `rvalid` = 0 and R payload = 0.
  - On `s_rvalid & s_rready & s_rlast`: go to IDLE and set `rr_ptr` = ~`arb_grant`.
- Outside ADDR, `s_arvalid` = 0 and all `m*_arready` = 0.
- Outside DATA, `s_rready` = 0 and all `m*_rvalid` = 0.
- No ID remapping and no checking. IDs, `rresp` (including SLVERR/DECERR) and burst length pass through unchanged.
- An ungranted master keeps its `arvalid` asserted, as AXI requires, until it is granted. It is never starved: after each completed burst, priority passes to the other master.

## Timing
- Reset value of every output, and of every payload output, is 0. Reset state is IDLE, `rr_ptr` = 0, `arb_grant` = 0.
- Arbitration latency is 1 cycle. If `arvalid` rises in cycle N while the block is in IDLE, `s_arvalid` rises in cycle N+1.
- The DATA→IDLE transition always costs one IDLE cycle. For back-to-back bursts, the next `s_arvalid` rises 2 cycles after the `rlast` handshake.
- In DATA, beats pass through combinationally with zero added latency. One beat per cycle is sustained when `s_rvalid` and `rready` are both held high.
- `s_arready` high in the first ADDR cycle: the AR handshake completes in that cycle, and the first R beat may arrive in the next cycle.
- `s_rvalid` beats that arrive while in ADDR are not possible (single slave, single outstanding transaction). Such beats are not accepted, because `s_rready` = 0.
- Asserting `rst` mid-burst immediately forces every output to 0 and returns the FSM to IDLE. Slave and masters are reset by the same `rst`.

## Structure
- AXI width macros are reused from the shared define file.
- Add the FSM state encodings `ARB_IDLE`, `ARB_ADDR`, `ARB_DATA` and the constant `ARB_STATE_W` = 2 to that file.
- One sub-module: `rr_pick2`. It is a combinational 2-way round-robin picker with inputs `req[1:0]` and `ptr`, and outputs `gnt_idx` and `gnt_vld`.
- The top level holds the FSM, the grant/pointer registers and the channel muxes.

## Test plan
- Single master: m0 issues `araddr`=0x100, `arlen`=3. Required response: `s_araddr`=0x100 one cycle after `arvalid`; 4 beats reach m0; m1 sees no `rvalid`; `rr_ptr`=1 afterwards.
- Simultaneous requests after reset: m0 `araddr`=0x0 and m1 `araddr`=0x40, both with `arlen`=0. Required response: m0 is served first; m1 is granted 1 cycle after m0's `rlast` handshake; `rr_ptr` ends at 0.
- Fairness: both masters request continuously for 8 bursts. Required response: grants alternate 0,1,0,1…; each master completes exactly 4 bursts.
- Back-pressure: `s_arready` is held low for 3 cycles, then m0 `rready` toggles every cycle on an `arlen`=7 burst. Required response: payload stays stable while stalled; 8 beats are delivered in order; `rid` and `rresp` pass through unchanged (rresp=2'b10 on beat 5 is delivered as is).
- Reset mid-burst: `rst` is asserted after beat 2 of 4. Required response: the same cycle, all outputs = 0 and state = IDLE; a new m1 request after reset is granted normally.

Source files
------------

// File: rtl/axi_rd_arb2_pkg.sv
// Shared AXI widths and arbiter state encodings for the ROM read-port arbiter.
package axi_rd_arb2_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb2_rr_pick2.sv
// Combinational 2-way round-robin picker: ptr names the favoured requester on a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    // Single requester wins outright; on a tie the pointer decides.
    always_comb begin
        gnt_vld = |req;
        if (req == 2'b11) gnt_idx = ptr;
        else              gnt_idx = req[1];
    end

endmodule

// File: rtl/axi_rd_arb2.sv
// Two-master AXI4 read arbiter in front of the instruction ROM.
// One transaction at a time; grant held from AR handshake through rlast.
module axi_rd_arb2
    import axi_rd_arb2_pkg::*;
#(
    parameter int ID_W   = AXI_ID_WIDTH,
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    // master 0
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic              m0_arlock,
    input  logic [3:0]        m0_arcache,
    input  logic [2:0]        m0_arprot,
    input  logic [3:0]        m0_arqos,
    input  logic [3:0]        m0_arregion,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    // master 1
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic              m1_arlock,
    input  logic [3:0]        m1_arcache,
    input  logic [2:0]        m1_arprot,
    input  logic [3:0]        m1_arqos,
    input  logic [3:0]        m1_arregion,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    // slave (ROM)
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic              s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic [3:0]        s_arqos,
    output logic [3:0]        s_arregion,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    // status
    output logic              arb_grant,
    output logic              arb_busy
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr, ptr_d;
    logic       pick_idx, pick_vld;

    rr_pick2 u_pick (
        .req     ({m1_arvalid, m0_arvalid}),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign arb_grant = grant_q;
    assign arb_busy  = (state_q == ARB_ADDR) || (state_q == ARB_DATA);

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr  <= ptr_d;
        end
    end

    // Next state plus channel muxes; everything idles at zero outside its phase.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = rr_ptr;
        s_arvalid   = 1'b0;
        s_arid      = '0;
        s_araddr    = '0;
        s_arlen     = '0;
        s_arsize    = '0;
        s_arburst   = '0;
        s_arlock    = 1'b0;
        s_arcache   = '0;
        s_arprot    = '0;
        s_arqos     = '0;
        s_arregion  = '0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        s_rready    = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rid      = '0;
        m0_rdata    = '0;
        m0_rresp    = '0;
        m0_rlast    = 1'b0;
        m1_rvalid   = 1'b0;
        m1_rid      = '0;
        m1_rdata    = '0;
        m1_rresp    = '0;
        m1_rlast    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (grant_q) begin
                    s_arvalid  = m1_arvalid;
                    s_arid     = m1_arid;
                    s_araddr   = m1_araddr;
                    s_arlen    = m1_arlen;
                    s_arsize   = m1_arsize;
                    s_arburst  = m1_arburst;
                    s_arlock   = m1_arlock;
                    s_arcache  = m1_arcache;
                    s_arprot   = m1_arprot;
                    s_arqos    = m1_arqos;
                    s_arregion = m1_arregion;
                    m1_arready = s_arready;
                end else begin
                    s_arvalid  = m0_arvalid;
                    s_arid     = m0_arid;
                    s_araddr   = m0_araddr;
                    s_arlen    = m0_arlen;
                    s_arsize   = m0_arsize;
                    s_arburst  = m0_arburst;
                    s_arlock   = m0_arlock;
                    s_arcache  = m0_arcache;
                    s_arprot   = m0_arprot;
                    s_arqos    = m0_arqos;
                    s_arregion = m0_arregion;
                    m0_arready = s_arready;
                end
                if (s_arvalid && s_arready) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                s_rready = grant_q ? m1_rready : m0_rready;
                if (grant_q) begin
                    m1_rvalid = s_rvalid;
                    m1_rid    = s_rid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rid    = s_rid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
                // Burst done: hand priority to the other master.
                if (s_rvalid && s_rready && s_rlast) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ~grant_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Scoreboard bench for axi_rd_arb2: stimulus pushes expected AR/R traffic,
// a negedge monitor pops and compares whenever the DUT presents it.
module tb_axi_rd_arb2;
    import axi_rd_arb2_pkg::*;

    localparam int IW = AXI_ID_WIDTH;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic m0_arvalid = 0, m1_arvalid = 0, m0_arready, m1_arready;
    logic [IW-1:0] m0_arid = '0, m1_arid = '0;
    logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
    logic [7:0] m0_arlen = '0, m1_arlen = '0;
    logic [2:0] m0_arsize = '0, m1_arsize = '0;
    logic [1:0] m0_arburst = '0, m1_arburst = '0;
    logic m0_arlock = 0, m1_arlock = 0;
    logic [3:0] m0_arcache = '0, m1_arcache = '0;
    logic [2:0] m0_arprot = '0, m1_arprot = '0;
    logic [3:0] m0_arqos = '0, m1_arqos = '0;
    logic [3:0] m0_arregion = '0, m1_arregion = '0;
    logic m0_rvalid, m1_rvalid, m0_rready = 1, m1_rready = 1;
    logic [IW-1:0] m0_rid, m1_rid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0] m0_rresp, m1_rresp;
    logic m0_rlast, m1_rlast;
    logic s_arvalid, s_arready = 1;
    logic [IW-1:0] s_arid;
    logic [AW-1:0] s_araddr;
    logic [7:0] s_arlen;
    logic [2:0] s_arsize;
    logic [1:0] s_arburst;
    logic s_arlock;
    logic [3:0] s_arcache;
    logic [2:0] s_arprot;
    logic [3:0] s_arqos;
    logic [3:0] s_arregion;
    logic s_rvalid = 0, s_rready;
    logic [IW-1:0] s_rid = '0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0] s_rresp = '0;
    logic s_rlast = 0;
    logic arb_grant, arb_busy;

    axi_rd_arb2 dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arlock(m0_arlock),
        .m0_arcache(m0_arcache), .m0_arprot(m0_arprot), .m0_arqos(m0_arqos), .m0_arregion(m0_arregion),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arlock(m1_arlock),
        .m1_arcache(m1_arcache), .m1_arprot(m1_arprot), .m1_arqos(m1_arqos), .m1_arregion(m1_arregion),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
        .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .arb_grant(arb_grant), .arb_busy(arb_busy)
    );

    logic outs_or;
    assign outs_or = |{m0_arready, m0_rvalid, m0_rid, m0_rdata, m0_rresp, m0_rlast,
                       m1_arready, m1_rvalid, m1_rid, m1_rdata, m1_rresp, m1_rlast,
                       s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
                       s_arcache, s_arprot, s_arqos, s_arregion, s_rready, arb_grant, arb_busy};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct { int m; logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;
    ar_t arq[$];
    r_t  rq0[$];
    r_t  rq1[$];

    task automatic exp_ar(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t e;
        e.m = m; e.id = id; e.addr = addr; e.len = len;
        arq.push_back(e);
    endtask

    // Expected beats: data = start address + beat index, error response on beat err.
    task automatic exp_r(input int m, input logic [IW-1:0] id, input logic [DW-1:0] addr,
                         input int total, input int push, input int err);
        r_t e;
        for (int i = 0; i < push; i++) begin
            e.id = id; e.data = addr + DW'(i);
            e.resp = (i == err) ? 2'b10 : 2'b00;
            e.last = (i == total - 1);
            if (m == 0) rq0.push_back(e); else rq1.push_back(e);
        end
    endtask

    // ---------------- slave (ROM) model ----------------
    int stall_cfg = 0;
    int err_idx_cfg = -1;
    initial begin
        logic ar_hs, r_hs, arv, busy;
        logic [IW-1:0] cap_id, id;
        logic [AW-1:0] cap_addr, base;
        int cap_len, len, beat, wait_cnt;
        busy = 0; beat = 0; len = 0; wait_cnt = 0; base = '0; id = '0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            arv   = s_arvalid;
            cap_id = s_arid; cap_addr = s_araddr; cap_len = int'(s_arlen);
            @(posedge clk); #1;
            if (rst) begin
                busy = 0; wait_cnt = 0; beat = 0;
            end else if (ar_hs) begin
                busy = 1; wait_cnt = 0; beat = 0;
                id = cap_id; base = cap_addr; len = cap_len;
            end else if (r_hs) begin
                if (beat == len) busy = 0; else beat++;
            end else if (arv && !busy) begin
                wait_cnt++;
            end
            s_rvalid  = busy;
            s_rlast   = busy && (beat == len);
            s_rdata   = busy ? DW'(base) + DW'(beat) : '0;
            s_rid     = busy ? id : '0;
            s_rresp   = (busy && beat == err_idx_cfg) ? 2'b10 : 2'b00;
            s_arready = !busy && (wait_cnt >= stall_cfg);
        end
    end

    // ---------------- master rready drivers ----------------
    bit tog0 = 0;
    initial forever begin
        @(posedge clk); #1;
        m0_rready = tog0 ? ~m0_rready : 1'b1;
        m1_rready = 1'b1;
    end

    // ---------------- monitor ----------------
    int r_cnt[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int rv_cnt[2] = '{0, 0};
    int rlast_cyc[2] = '{0, 0};
    int ar_cyc[2] = '{0, 0};

    task automatic check_beat(input int m, input logic [IW-1:0] id, input logic [DW-1:0] data,
                              input logic [1:0] resp, input logic last);
        r_t e;
        if ((m == 0 && rq0.size() == 0) || (m == 1 && rq1.size() == 0)) begin
            $display("FAIL unexpected R beat on m%0d: data 0x%0h, none expected", m, data);
            vectors++; miscompares++;
        end else begin
            e = (m == 0) ? rq0.pop_front() : rq1.pop_front();
            chk($sformatf("m%0d rid", m), id, e.id);
            chk($sformatf("m%0d rdata", m), data, e.data);
            chk($sformatf("m%0d rresp", m), resp, e.resp);
            chk($sformatf("m%0d rlast", m), last, e.last);
            r_cnt[m]++;
            if (last) begin done_cnt[m]++; rlast_cyc[m] = cyc; end
        end
    endtask

    initial begin
        ar_t e;
        bit st_pend;
        logic [DW-1:0] st_data;
        st_pend = 0; st_data = '0;
        forever begin
            @(negedge clk);
            if (m0_rvalid && m1_rvalid) fail_now("both masters see rvalid");
            if (m0_rvalid) rv_cnt[0]++;
            if (m1_rvalid) rv_cnt[1]++;
            // A stalled m0 beat must be held unchanged until accepted.
            if (st_pend && !rst) begin
                chk("m0 stalled rvalid held", m0_rvalid, 1'b1);
                chk("m0 stalled rdata held", m0_rdata, st_data);
            end
            st_pend = m0_rvalid && !m0_rready;
            st_data = m0_rdata;
            if (m0_rvalid && m0_rready) check_beat(0, m0_rid, m0_rdata, m0_rresp, m0_rlast);
            if (m1_rvalid && m1_rready) check_beat(1, m1_rid, m1_rdata, m1_rresp, m1_rlast);
            if (s_arvalid) begin
                if (arq.size() == 0) begin
                    $display("FAIL unexpected AR: addr 0x%0h, none expected", s_araddr);
                    vectors++; miscompares++;
                end else begin
                    e = arq[0];
                    chk("ar grant", arb_grant, e.m);
                    chk("ar addr", s_araddr, e.addr);
                    chk("ar id", s_arid, e.id);
                    chk("ar len", s_arlen, e.len);
                    chk("ar burst", s_arburst, 2'b01);
                    chk("ar ready route", (e.m == 0) ? m0_arready : m1_arready, s_arready);
                    if (s_arready) begin
                        void'(arq.pop_front());
                        ar_cyc[e.m] = cyc;
                    end
                end
            end
        end
    end

    // ---------------- master AR driver ----------------
    task automatic issue(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, output int lat);
        bit done;
        done = 0; lat = 0;
        @(posedge clk); #1;
        if (m == 0) begin
            m0_arvalid = 1; m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'd1;
        end else begin
            m1_arvalid = 1; m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'd1;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            lat++;
            done = (m == 0) ? (m0_arvalid && m0_arready) : (m1_arvalid && m1_arready);
        end
        @(posedge clk); #1;
        if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
        if (!done) fail_now($sformatf("ar handshake m%0d timed out", m));
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (arq.size() == 0) && (rq0.size() == 0) && (rq1.size() == 0);
        end
        if (!ok) fail_now($sformatf("%s: expected traffic not drained", name));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat0, lat1, rv1, d0, d1, base;
        bit hit;

        // Reset state
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs zero", outs_or, 1'b0);
        chk("reset state", dut.state_q, ARB_IDLE);
        chk("reset rr_ptr", dut.rr_ptr, 1'b0);
        @(posedge clk); #1;
        rst = 0;

        // Single master, 4 beats
        exp_ar(0, 4'h1, 32'h100, 8'd3);
        exp_r(0, 4'h1, 32'h100, 4, 4, -1);
        rv1 = rv_cnt[1];
        d0 = done_cnt[0];
        issue(0, 4'h1, 32'h100, 8'd3, lat0);
        chk("t1 arb latency", lat0, 2);
        drain("t1");
        chk("t1 rr_ptr", dut.rr_ptr, 1'b1);
        chk("t1 m1 saw rvalid", rv_cnt[1] - rv1, 0);
        chk("t1 bursts", done_cnt[0] - d0, 1);

        // Simultaneous requests right after reset
        @(posedge clk); #1; rst = 1;
        repeat (2) @(posedge clk); #1; rst = 0;
        exp_ar(0, 4'h2, 32'h0, 8'd0);
        exp_ar(1, 4'h3, 32'h40, 8'd0);
        exp_r(0, 4'h2, 32'h0, 1, 1, -1);
        exp_r(1, 4'h3, 32'h40, 1, 1, -1);
        fork
            issue(0, 4'h2, 32'h0, 8'd0, lat0);
            issue(1, 4'h3, 32'h40, 8'd0, lat1);
        join
        drain("t2");
        chk("t2 m0 latency", lat0, 2);
        chk("t2 m1 AR after m0 rlast", ar_cyc[1] - rlast_cyc[0], 2);
        chk("t2 rr_ptr", dut.rr_ptr, 1'b0);

        // Fairness: 8 back-to-back bursts alternate
        d0 = done_cnt[0]; d1 = done_cnt[1];
        for (int i = 0; i < 4; i++) begin
            exp_ar(0, 4'h4, 32'h200 + 32'(16 * i), 8'd1);
            exp_ar(1, 4'h5, 32'h300 + 32'(16 * i), 8'd1);
            exp_r(0, 4'h4, 32'h200 + 32'(16 * i), 2, 2, -1);
            exp_r(1, 4'h5, 32'h300 + 32'(16 * i), 2, 2, -1);
        end
        fork
            for (int i = 0; i < 4; i++) issue(0, 4'h4, 32'h200 + 32'(16 * i), 8'd1, lat0);
            for (int j = 0; j < 4; j++) issue(1, 4'h5, 32'h300 + 32'(16 * j), 8'd1, lat1);
        join
        drain("t3");
        chk("t3 m0 bursts", done_cnt[0] - d0, 4);
        chk("t3 m1 bursts", done_cnt[1] - d1, 4);
        chk("t3 rr_ptr", dut.rr_ptr, 1'b0);

        // Back-pressure: arready low 3 cycles, m0 rready toggling, SLVERR on beat 5
        stall_cfg = 3; err_idx_cfg = 4; tog0 = 1;
        repeat (2) @(posedge clk);
        exp_ar(0, 4'h9, 32'h500, 8'd7);
        exp_r(0, 4'h9, 32'h500, 8, 8, 4);
        issue(0, 4'h9, 32'h500, 8'd7, lat0);
        chk("t4 ar stall latency", lat0, 5);
        drain("t4");
        tog0 = 0; stall_cfg = 0; err_idx_cfg = -1;
        chk("t4 rr_ptr", dut.rr_ptr, 1'b1);

        // Reset after beat 2 of 4
        repeat (2) @(posedge clk);
        exp_ar(0, 4'h6, 32'h600, 8'd3);
        exp_r(0, 4'h6, 32'h600, 4, 2, -1);
        base = r_cnt[0];
        issue(0, 4'h6, 32'h600, 8'd3, lat0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (r_cnt[0] >= base + 2) hit = 1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) fail_now("t5 beats before reset never arrived");
        rst = 1;
        #1;
        chk("t5 outputs zero in reset", outs_or, 1'b0);
        chk("t5 state in reset", dut.state_q, ARB_IDLE);
        repeat (2) @(posedge clk); #1;
        rst = 0;
        chk("t5 no leftover beats", rq0.size(), 0);
        exp_ar(1, 4'h7, 32'h700, 8'd1);
        exp_r(1, 4'h7, 32'h700, 2, 2, -1);
        d1 = done_cnt[1];
        issue(1, 4'h7, 32'h700, 8'd1, lat1);
        chk("t5 m1 latency after reset", lat1, 2);
        drain("t5");
        chk("t5 m1 burst", done_cnt[1] - d1, 1);
        chk("t5 rr_ptr", dut.rr_ptr, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
